// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
// Module : pci_pkg
// Brief  : Shared PCI target constants: bus commands, FSM states, signal levels.
// Rev    : 1.0  initial release
// ============================================================================
package pci_pkg;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TURN = 2'd2
    } state_e;

endpackage : pci_pkg
`default_nettype wire

// File: rtl/pci_burst_ctr.sv
`default_nettype none
// ============================================================================
// Module : pci_burst_ctr
// Brief  : Linear burst word counter; loads, increments, saturates at the top
//          of the window and raises a sticky end flag there.
// Rev    : 1.0  initial release
// ============================================================================
module pci_burst_ctr #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              end_o
);

    localparam logic [ADDR_W-1:0] C_MAX = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              end_q, end_d;

    always_comb begin
        addr_d = addr_q;
        end_d  = end_q;
        if (load_i) begin
            addr_d = load_val_i;
            end_d  = 1'b0;
        end else if (inc_i) begin
            // No wrap: the last word of the window is held and flagged.
            if (addr_q == C_MAX) begin
                end_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            end_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            end_q  <= end_d;
        end
    end

    assign addr_o = addr_q;
    assign end_o  = end_q;

endmodule : pci_burst_ctr
`default_nettype wire

// File: rtl/pci_target_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pci_target_ctrl
// Brief  : PCI memory target: address decode, DEVSEL#/storageControl, burst
//          tracking and local buffer strobes. Option macro: PCI_TARGET_STOP_EN.
// Rev    : 1.0  initial release
// ============================================================================
module pci_target_ctrl
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame,
    input  logic              irdy,
    input  logic [31:0]       ad,
    input  logic [3:0]        cbe,
    input  logic              Trdy,
    output logic              devsel,
    output logic              storageControl,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic              stop
);

    localparam logic [ADDR_W-1:0] C_MAX = {ADDR_W{1'b1}};

    state_e state_q, state_d;
    logic   devsel_q, devsel_d;
    logic   sc_q, sc_d;
    logic   is_wr_q, is_wr_d;

    logic w_hit, w_cmd_ok, w_accept, w_xfer, w_exit, w_end;
    logic unused_ad;

    assign unused_ad = ^ad[1:0];

    assign w_hit    = (ad[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign w_cmd_ok = (cbe == CMD_MEM_RD) || (cbe == CMD_MEM_WR);
    assign w_accept = (state_q == IDLE) && (frame == ASSERTED) && w_hit && w_cmd_ok;
    assign w_xfer   = (state_q == DATA) && (irdy == ASSERTED) && (Trdy == ASSERTED);

    // Leave DATA on the final transfer, a master abort, or once the master
    // deasserts FRAME# after the window end has been reached.
    assign w_exit = (state_q == DATA) && (frame == DEASSERTED) &&
                    (w_xfer || (irdy == DEASSERTED) || w_end);

    pci_burst_ctr #(
        .ADDR_W (ADDR_W)
    ) u_burst_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_accept),
        .load_val_i (ad[ADDR_W+1:2]),
        .inc_i      (w_xfer),
        .addr_o     (mem_addr),
        .end_o      (w_end)
    );

    always_comb begin
        state_d  = state_q;
        devsel_d = devsel_q;
        sc_d     = sc_q;
        is_wr_d  = is_wr_q;
        unique case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d  = DATA;
                    devsel_d = ASSERTED;
                    sc_d     = 1'b1;
                    is_wr_d  = (cbe == CMD_MEM_WR);
                end
            end
            DATA: begin
                if (w_exit) begin
                    state_d  = TURN;
                    devsel_d = DEASSERTED;
                    sc_d     = 1'b0;
                end else if (w_xfer && (mem_addr == C_MAX)) begin
                    sc_d = 1'b0;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                devsel_d = DEASSERTED;
                sc_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            devsel_q <= DEASSERTED;
            sc_q     <= 1'b0;
            is_wr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            devsel_q <= devsel_d;
            sc_q     <= sc_d;
            is_wr_q  <= is_wr_d;
        end
    end

    // Strobes mark the cycle whose closing edge completes a data phase.
    assign mem_we         = !rst && w_xfer &&  is_wr_q;
    assign mem_re         = !rst && w_xfer && !is_wr_q;
    assign devsel         = devsel_q;
    assign storageControl = sc_q;

`ifdef PCI_TARGET_STOP_EN
    logic stop_q, stop_d;

    always_comb begin
        stop_d = stop_q;
        if (w_exit) begin
            stop_d = DEASSERTED;
        end else if (w_xfer && (mem_addr == C_MAX) && (frame == ASSERTED)) begin
            stop_d = ASSERTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stop_q <= DEASSERTED;
        end else begin
            stop_q <= stop_d;
        end
    end

    assign stop = stop_q;
`else
    assign stop = DEASSERTED;
`endif

endmodule : pci_target_ctrl
`default_nettype wire

// File: tb/tb_pci_target_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pci_target_ctrl
// Brief  : Directed bench for pci_target_ctrl with a TRDY stage model closing
//          the Trdy loop. Honours PCI_TARGET_STOP_EN.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pci_target_ctrl;

    logic        clk;
    logic        rst;
    logic        frame;
    logic        irdy;
    logic [31:0] ad;
    logic [3:0]  cbe;
    logic        Trdy;
    logic        devsel;
    logic        storageControl;
    logic [3:0]  mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic        stop;

    int n_checks;
    int n_errors;

`ifdef PCI_TARGET_STOP_EN
    localparam logic C_STOP_AT_END = 1'b0;
`else
    localparam logic C_STOP_AT_END = 1'b1;
`endif

    pci_target_ctrl #(
        .BASE_ADDR (32'h0000_1000),
        .ADDR_W    (4)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .frame          (frame),
        .irdy           (irdy),
        .ad             (ad),
        .cbe            (cbe),
        .Trdy           (Trdy),
        .devsel         (devsel),
        .storageControl (storageControl),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .stop           (stop)
    );

    // TRDY stage: follows devsel only while storage is ready.
    assign Trdy = !((devsel == 1'b0) && storageControl);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply bus inputs for one cycle; checks follow at the negedge.
    task automatic drive(input logic f, input logic i, input logic [31:0] a, input logic [3:0] c);
        frame = f;
        irdy  = i;
        ad    = a;
        cbe   = c;
        @(negedge clk);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        next_edge();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        frame = 1'b1;
        irdy  = 1'b1;
        ad    = 32'h0;
        cbe   = 4'h0;
        repeat (2) next_edge();
        rst = 1'b0;

        // Reset state
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        check("rst_devsel", 32'(devsel), 32'd1);
        check("rst_sc", 32'(storageControl), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_stop", 32'(stop), 32'd1);
        next_edge();

        // Single write at index 2
        drive(1'b0, 1'b1, 32'h0000_1008, 4'b0111);
        check("wr_devsel_addrph", 32'(devsel), 32'd1);
        next_edge();
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        check("wr_devsel", 32'(devsel), 32'd0);
        check("wr_sc", 32'(storageControl), 32'd1);
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_re", 32'(mem_re), 32'd0);
        check("wr_addr", 32'(mem_addr), 32'd2);
        next_edge();
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        check("wr_turn_devsel", 32'(devsel), 32'd1);
        check("wr_turn_we", 32'(mem_we), 32'd0);
        next_edge();
        bus_idle();

        // Miss and unsupported command
        drive(1'b0, 1'b1, 32'h0000_2000, 4'b0111);
        next_edge();
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        check("miss_devsel", 32'(devsel), 32'd1);
        check("miss_we", 32'(mem_we), 32'd0);
        next_edge();
        drive(1'b0, 1'b1, 32'h0000_1000, 4'b0010);
        next_edge();
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        check("unsup_devsel", 32'(devsel), 32'd1);
        check("unsup_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        next_edge();
        bus_idle();

        // Burst read of 4 words with an irdy wait at phase 2
        drive(1'b0, 1'b1, 32'h0000_1000, 4'b0110);
        next_edge();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        check("rd0_re", 32'(mem_re), 32'd1);
        check("rd0_addr", 32'(mem_addr), 32'd0);
        next_edge();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        check("rd1_re", 32'(mem_re), 32'd1);
        check("rd1_addr", 32'(mem_addr), 32'd1);
        next_edge();
        drive(1'b0, 1'b1, 32'h0, 4'h0);
        check("rd_wait_re", 32'(mem_re), 32'd0);
        check("rd_wait_addr", 32'(mem_addr), 32'd2);
        check("rd_wait_devsel", 32'(devsel), 32'd0);
        next_edge();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        check("rd2_re", 32'(mem_re), 32'd1);
        check("rd2_addr", 32'(mem_addr), 32'd2);
        next_edge();
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        check("rd3_re", 32'(mem_re), 32'd1);
        check("rd3_we", 32'(mem_we), 32'd0);
        check("rd3_addr", 32'(mem_addr), 32'd3);
        next_edge();
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        check("rd_end_devsel", 32'(devsel), 32'd1);
        check("rd_end_re", 32'(mem_re), 32'd0);
        next_edge();
        bus_idle();

        // Window boundary: write burst of 3 starting at index 15
        drive(1'b0, 1'b1, 32'h0000_103C, 4'b0111);
        next_edge();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        check("bnd0_we", 32'(mem_we), 32'd1);
        check("bnd0_addr", 32'(mem_addr), 32'd15);
        next_edge();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        check("bnd1_we", 32'(mem_we), 32'd0);
        check("bnd1_sc", 32'(storageControl), 32'd0);
        check("bnd1_addr", 32'(mem_addr), 32'd15);
        check("bnd1_stop", 32'(stop), 32'(C_STOP_AT_END));
        check("bnd1_devsel", 32'(devsel), 32'd0);
        next_edge();
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        check("bnd2_we", 32'(mem_we), 32'd0);
        check("bnd2_stop", 32'(stop), 32'(C_STOP_AT_END));
        next_edge();
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        check("bnd_turn_devsel", 32'(devsel), 32'd1);
        check("bnd_turn_stop", 32'(stop), 32'd1);
        check("bnd_turn_addr", 32'(mem_addr), 32'd15);
        next_edge();
        bus_idle();

        // Back-to-back: address phase during TURN ignored, next IDLE accepted
        drive(1'b0, 1'b1, 32'h0000_1008, 4'b0111);
        next_edge();
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        check("b2b_we0", 32'(mem_we), 32'd1);
        next_edge();
        drive(1'b0, 1'b1, 32'h0000_1004, 4'b0111);
        check("b2b_turn_devsel", 32'(devsel), 32'd1);
        next_edge();
        drive(1'b0, 1'b1, 32'h0000_1004, 4'b0111);
        check("b2b_idle_devsel", 32'(devsel), 32'd1);
        next_edge();
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        check("b2b_devsel", 32'(devsel), 32'd0);
        check("b2b_we1", 32'(mem_we), 32'd1);
        check("b2b_addr", 32'(mem_addr), 32'd1);
        next_edge();
        bus_idle();

        // Reset in the middle of a data phase
        drive(1'b0, 1'b1, 32'h0000_1014, 4'b0111);
        next_edge();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        check("mrst_we_gated", 32'(mem_we), 32'd0);
        next_edge();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        check("mrst_devsel", 32'(devsel), 32'd1);
        check("mrst_sc", 32'(storageControl), 32'd0);
        check("mrst_addr", 32'(mem_addr), 32'd0);
        check("mrst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        next_edge();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        check("mrst_after_devsel", 32'(devsel), 32'd1);
        check("mrst_after_we", 32'(mem_we), 32'd0);
        next_edge();
        bus_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pci_target_ctrl
`default_nettype wire
